// File: rtl/in_to_fifo.sv
// in_to_fifo: four-phase byte source to FIFO writer; fifo_we 1 edge after capture, in_finish 1 edge later.
// Backpressure: fifo_busy/fifo_full stall in S_PUSH, or with IN_TO_FIFO_DROP_EN a full FIFO drops the byte and still acks.
module in_to_fifo #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               in_start,
  input  logic [7:0]         in_data,
  output logic               in_finish,
  input  logic               fifo_busy,
  input  logic               fifo_full,
  output logic               fifo_we,
  output logic [7:0]         fifo_data,
  output logic               isFinish,
  output logic [COUNT_W-1:0] byte_count,
  output logic [7:0]         drop_count,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_PUSH = 3'd2,
    S_ACK  = 3'd3
  } state_t;

  logic [2:0]         state_nxt;
  logic               we_nxt;
  logic               fin_nxt;
  logic               isf_nxt;
  logic [7:0]         data_nxt;
  logic [COUNT_W-1:0] bc_nxt;
`ifdef IN_TO_FIFO_DROP_EN
  logic [7:0]         drop_nxt;
`endif

  always_comb begin
    state_nxt = state;
    we_nxt    = 1'b0;
    fin_nxt   = in_finish;
    isf_nxt   = isFinish;
    data_nxt  = fifo_data;
    bc_nxt    = byte_count;
`ifdef IN_TO_FIFO_DROP_EN
    drop_nxt  = drop_count;
`endif
    case (state)
      S_IDLE: begin
        fin_nxt   = 1'b0;
        isf_nxt   = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (in_start) begin
          data_nxt  = in_data;
          isf_nxt   = 1'b0;
          state_nxt = S_PUSH;
        end
      end
      S_PUSH: begin
        // busy is checked first so it always wins over full
        if (!fifo_busy && !fifo_full) begin
          we_nxt    = 1'b1;
          bc_nxt    = byte_count + 1'b1;
          state_nxt = S_ACK;
        end
`ifdef IN_TO_FIFO_DROP_EN
        else if (!fifo_busy) begin
          if (drop_count != 8'hFF) drop_nxt = drop_count + 8'd1;
          state_nxt = S_ACK;
        end
`endif
      end
      S_ACK: begin
        if (in_start) begin
          fin_nxt = 1'b1;
        end else begin
          fin_nxt   = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        fin_nxt   = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      fifo_we    <= 1'b0;
      in_finish  <= 1'b0;
      fifo_data  <= 8'd0;
      isFinish   <= 1'b1;
      byte_count <= '0;
    end else if (enable) begin
      state      <= state_nxt;
      fifo_we    <= we_nxt;
      in_finish  <= fin_nxt;
      fifo_data  <= data_nxt;
      isFinish   <= isf_nxt;
      byte_count <= bc_nxt;
    end else begin
      fifo_we <= 1'b0;
    end
  end

`ifdef IN_TO_FIFO_DROP_EN
  always_ff @(posedge clk) begin
    if (!rst_n)      drop_count <= 8'd0;
    else if (enable) drop_count <= drop_nxt;
  end
`else
  assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_in_to_fifo.sv
// Bench for in_to_fifo: cycle vector table, full-FIFO sequence, then random handshakes vs a transaction model.
module tb_in_to_fifo;

`ifdef IN_TO_FIFO_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        in_start = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_finish;
  logic        fifo_busy = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_we;
  logic [7:0]  fifo_data;
  logic        isFinish;
  logic [15:0] byte_count;
  logic [7:0]  drop_count;
  logic [2:0]  state;

  int nvec = 0;
  int nerr = 0;

  in_to_fifo #(.COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_start(in_start), .in_data(in_data),
    .in_finish(in_finish), .fifo_busy(fifo_busy), .fifo_full(fifo_full), .fifo_we(fifo_we),
    .fifo_data(fifo_data), .isFinish(isFinish), .byte_count(byte_count),
    .drop_count(drop_count), .state(state)
  );

  always #5 clk = ~clk;

  // ctl = {rst_n, enable, in_start, fifo_busy, fifo_full}; flg = {fifo_we, in_finish, isFinish}
  typedef struct {
    logic [4:0]  ctl;
    logic [7:0]  d;
    logic [2:0]  e_st;
    logic [2:0]  e_flg;
    logic [7:0]  e_dat;
    logic [15:0] e_bc;
  } vec_t;

  vec_t vq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic src_req, pv_busy, pv_full, pv_en, got;
    int hs, wes;

    // reset (ignores enable), first transfer 0xA5, busy stall, enable hold, resets in ACK and PUSH
    vq.push_back('{5'b00000, 8'h00, 3'd0, 3'b001, 8'h00, 16'd0});
    vq.push_back('{5'b01000, 8'h00, 3'd0, 3'b001, 8'h00, 16'd0});
    vq.push_back('{5'b11000, 8'h00, 3'd1, 3'b001, 8'h00, 16'd0});
    vq.push_back('{5'b11000, 8'h00, 3'd1, 3'b001, 8'h00, 16'd0});
    vq.push_back('{5'b11100, 8'hA5, 3'd2, 3'b000, 8'hA5, 16'd0});
    vq.push_back('{5'b11100, 8'hA5, 3'd3, 3'b100, 8'hA5, 16'd1});
    vq.push_back('{5'b11100, 8'hA5, 3'd3, 3'b010, 8'hA5, 16'd1});
    vq.push_back('{5'b11100, 8'hA5, 3'd3, 3'b010, 8'hA5, 16'd1});
    vq.push_back('{5'b11000, 8'hA5, 3'd0, 3'b000, 8'hA5, 16'd1});
    vq.push_back('{5'b11000, 8'h00, 3'd1, 3'b001, 8'hA5, 16'd1});
    vq.push_back('{5'b11110, 8'h3C, 3'd2, 3'b000, 8'h3C, 16'd1});
    vq.push_back('{5'b11110, 8'h3C, 3'd2, 3'b000, 8'h3C, 16'd1});
    vq.push_back('{5'b11111, 8'h3C, 3'd2, 3'b000, 8'h3C, 16'd1});
    vq.push_back('{5'b10100, 8'h3C, 3'd2, 3'b000, 8'h3C, 16'd1});
    vq.push_back('{5'b10100, 8'h3C, 3'd2, 3'b000, 8'h3C, 16'd1});
    vq.push_back('{5'b10100, 8'h3C, 3'd2, 3'b000, 8'h3C, 16'd1});
    vq.push_back('{5'b11100, 8'h3C, 3'd3, 3'b100, 8'h3C, 16'd2});
    vq.push_back('{5'b10100, 8'h3C, 3'd3, 3'b000, 8'h3C, 16'd2});
    vq.push_back('{5'b11100, 8'h3C, 3'd3, 3'b010, 8'h3C, 16'd2});
    vq.push_back('{5'b11000, 8'h3C, 3'd0, 3'b000, 8'h3C, 16'd2});
    vq.push_back('{5'b11000, 8'h00, 3'd1, 3'b001, 8'h3C, 16'd2});
    vq.push_back('{5'b11100, 8'h5A, 3'd2, 3'b000, 8'h5A, 16'd2});
    vq.push_back('{5'b11100, 8'h5A, 3'd3, 3'b100, 8'h5A, 16'd3});
    vq.push_back('{5'b11100, 8'h5A, 3'd3, 3'b010, 8'h5A, 16'd3});
    vq.push_back('{5'b01100, 8'h5A, 3'd0, 3'b001, 8'h00, 16'd0});
    vq.push_back('{5'b11100, 8'h77, 3'd1, 3'b001, 8'h00, 16'd0});
    vq.push_back('{5'b11110, 8'h77, 3'd2, 3'b000, 8'h77, 16'd0});
    vq.push_back('{5'b01100, 8'h77, 3'd0, 3'b001, 8'h00, 16'd0});
    vq.push_back('{5'b11000, 8'h00, 3'd1, 3'b001, 8'h00, 16'd0});
    vq.push_back('{5'b11100, 8'h99, 3'd2, 3'b000, 8'h99, 16'd0});
    vq.push_back('{5'b11100, 8'h99, 3'd3, 3'b100, 8'h99, 16'd1});
    vq.push_back('{5'b11100, 8'h99, 3'd3, 3'b010, 8'h99, 16'd1});
    vq.push_back('{5'b01100, 8'h99, 3'd0, 3'b001, 8'h00, 16'd0});

    foreach (vq[i]) begin
      {rst_n, enable, in_start, fifo_busy, fifo_full} = vq[i].ctl;
      in_data = vq[i].d;
      tick();
      chk($sformatf("vec%0d_out", i), {state, fifo_we, in_finish, isFinish, fifo_data},
          {vq[i].e_st, vq[i].e_flg, vq[i].e_dat});
      chk($sformatf("vec%0d_cnt", i), {drop_count, byte_count}, {8'd0, vq[i].e_bc});
    end

    // full FIFO during S_PUSH; state is S_IDLE with byte_count 0 here
    rst_n = 1'b1; enable = 1'b1; fifo_busy = 1'b0;
`ifndef IN_TO_FIFO_DROP_EN
    in_start = 1'b0; tick();
    chk("full_wait", state, 3'd1);
    in_start = 1'b1; in_data = 8'hC3; tick();
    chk("full_cap", state, 3'd2);
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("full_stall%0d", k), {state, fifo_we}, {3'd2, 1'b0});
    end
    fifo_full = 1'b0; tick();
    chk("full_write", {state, fifo_we, fifo_data}, {3'd3, 1'b1, 8'hC3});
    chk("full_bc", byte_count, 16'd1);
    tick();
    chk("full_ack", in_finish, 1'b1);
    in_start = 1'b0; tick();
    chk("full_release", {state, in_finish}, {3'd0, 1'b0});
    chk("full_nodrop", drop_count, 8'd0);
`else
    fifo_full = 1'b1;
    hs = 0; wes = 0;
    for (int i = 0; i < 300; i++) begin
      in_start = 1'b1; in_data = i[7:0];
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        tick();
        if (fifo_we) wes++;
        if (in_finish) got = 1'b1;
      end
      chk($sformatf("drop_ack%0d", i), got, 1'b1);
      in_start = 1'b0;
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        tick();
        if (fifo_we) wes++;
        if (!in_finish) got = 1'b1;
      end
      chk($sformatf("drop_rel%0d", i), got, 1'b1);
      hs++;
    end
    chk("drop_no_we", wes, 0);
    chk("drop_sat", drop_count, (hs > 255) ? 255 : hs);
    chk("drop_bc", byte_count, 16'd0);
    fifo_full = 1'b0;
`endif

    // random handshakes: every completed handshake must have produced exactly one write of its byte
    rst_n = 1'b0; in_start = 1'b0; tick();
    rst_n = 1'b1;
    src_req = 1'b0; hs = 0;
    for (int c = 0; c < 4000; c++) begin
      fifo_busy = ($urandom_range(0, 3) == 0);
      fifo_full = DROP ? 1'b0 : ($urandom_range(0, 4) == 0);
      enable    = ($urandom_range(0, 7) != 0);
      if (c >= 3500) begin
        fifo_busy = 1'b0; fifo_full = 1'b0; enable = 1'b1;
      end
      if (!src_req) begin
        if (!in_finish && c < 3400 && $urandom_range(0, 1) == 1) begin
          src_req = 1'b1; in_start = 1'b1; in_data = 8'($urandom);
          q.push_back(in_data);
        end
      end else if (in_finish) begin
        chk("hs_write", q.size(), 0);
        src_req = 1'b0; in_start = 1'b0; hs++;
      end
      pv_busy = fifo_busy; pv_full = fifo_full; pv_en = enable;
      tick();
      if (fifo_we) begin
        chk("we_gate", {pv_busy, pv_full, pv_en}, 3'b001);
        chk("we_pending", q.size() != 0, 1'b1);
        if (q.size() != 0) chk("we_data", fifo_data, q.pop_front());
      end
    end
    chk("rand_idle", {src_req, state}, {1'b0, 3'd1});
    chk("rand_bc", byte_count, hs[15:0]);
    chk("rand_drop", drop_count, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/in_to_fifo.md
IN_TO_FIFO -- requirements
Module: in_to_fifo

Interface
REQ-001 SHALL have parameter COUNT_W, default 16: width of the written-byte counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port enable  input  1  1 = block advances; 0 = block holds state.
REQ-005 SHALL have port in_start  input  1  source request; in_data valid while high.
REQ-006 SHALL have port in_data  input  8  byte offered by the source.
REQ-007 SHALL have port in_finish  output  1  acknowledge to the source.
REQ-008 SHALL have port fifo_busy  input  1  FIFO cannot accept a write this cycle.
REQ-009 SHALL have port fifo_full  input  1  FIFO full.
REQ-010 SHALL have port fifo_we  output  1  FIFO write strobe, one-cycle pulse.
REQ-011 SHALL have port fifo_data  output  8  byte presented to the FIFO.
REQ-012 SHALL have port isFinish  output  1  1 = idle, no transfer in flight.
REQ-013 SHALL have port byte_count  output  COUNT_W  bytes written, wraps modulo 2^COUNT_W.
REQ-014 SHALL have port drop_count  output  8  bytes dropped, saturates at 255.
REQ-015 SHALL have port state  output  3  current FSM state, for debug.

Function
REQ-016 SHALL register all outputs and update them only on the rising edge of clk.
REQ-017 SHALL use state encoding S_IDLE=0, S_WAIT=1, S_PUSH=2, S_ACK=3; any value from 4 to 7 SHALL return to S_IDLE on the next edge.
REQ-018 In S_IDLE: fifo_we=0, in_finish=0, isFinish=1; next state S_WAIT.
REQ-019 In S_WAIT with in_start=1: fifo_data<=in_data, isFinish<=0, next state S_PUSH; with in_start=0 the block SHALL remain in S_WAIT.
REQ-020 In S_PUSH with fifo_busy=0 and fifo_full=0: fifo_we<=1 for exactly one cycle, byte_count<=byte_count+1, next state S_ACK.
REQ-021 In S_PUSH with fifo_busy=1 or fifo_full=1: fifo_we=0 and the block SHALL stall in S_PUSH; see REQ-030 for the alternative behaviour.
REQ-022 In S_ACK: fifo_we<=0, in_finish<=1; when in_start=0 is sampled, in_finish<=0 and next state S_IDLE.
REQ-023 Latency: in_start sampled high in S_WAIT at edge N, FIFO ready -> fifo_we high after edge N+1, in_finish high after edge N+2.
REQ-024 SHALL write exactly one FIFO entry per four-phase in_start/in_finish handshake, never two.
REQ-025 When enable=0: state, fifo_data, counters, in_finish and isFinish SHALL hold; fifo_we SHALL be 0 from the next edge; a write pending in S_PUSH SHALL resume once enable returns to 1.
REQ-026 fifo_busy SHALL take priority over fifo_full; either one blocks the write.

Reset
REQ-027 rst_n=0 sampled at an edge SHALL force state=S_IDLE, fifo_we=0, in_finish=0, fifo_data=0, isFinish=1, byte_count=0, drop_count=0, regardless of enable.
REQ-028 Reset mid-transfer (S_PUSH or S_ACK) SHALL abandon the byte with no FIFO write and no count update; the source SHALL see in_finish fall.
REQ-029 After rst_n returns to 1, the first active edge SHALL leave S_IDLE for S_WAIT.

Configuration
REQ-030 Macro IN_TO_FIFO_DROP_EN defined: in S_PUSH with fifo_full=1 and fifo_busy=0, no write occurs, drop_count increments (saturating at 255), and the state advances to S_ACK so the source is still acknowledged.
REQ-031 Macro IN_TO_FIFO_DROP_EN undefined: stall per REQ-021; drop_count SHALL be tied to 0.

Verification
REQ-032 Reset, then in_start=1 with in_data=0xA5, FIFO ready -> one fifo_we pulse with fifo_data=0xA5, in_finish=1 two edges after capture, byte_count=1.
REQ-033 fifo_full=1 for 5 cycles during S_PUSH (drop disabled) -> fifo_we stays 0 and state=2 throughout; write occurs on the first edge after fifo_full falls.
REQ-034 With IN_TO_FIFO_DROP_EN defined, fifo_full=1, send 300 bytes -> no fifo_we pulses, drop_count=255, every handshake completes.
REQ-035 enable=0 asserted while in S_PUSH for 3 cycles -> no fifo_we and state holds at 2; the write completes after enable=1.
REQ-036 rst_n=0 while in S_ACK with in_start still high -> in_finish=0, state=0, isFinish=1, byte_count unchanged from its pre-transfer value of 0.
